box_sprite_compositor: RTL

Parametrised successor to the fixed two-box overlay in the VGA path. Renders `NUM_BOXES` solid-colour rectangles over a background pixel stream, with per-box centre, half-size, colour and enable. Geometry is shadow-latched once per frame so boxes never tear mid-frame. Sits between the timing generator / background palette lookup and the `VGA_R/G/B` outputs, and optionally reports per-frame overlap between box 0 (player) and every other box.

---
 rtl/box_sprite_compositor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/box_sprite_compositor.sv
// box_sprite_compositor: frame-latched NUM_BOXES box overlay on a pixel stream, 2-cycle latency.
// Define BOX_COLLISION_EN to build the per-frame box-0 overlap flags.
module box_sprite_compositor #(
   parameter int NUM_BOXES  = 4,
   parameter int X_WIDTH    = 10,
   parameter int Y_WIDTH    = 9,
   parameter int HALF_WIDTH = 6,
   parameter int COLOR_BITS = 12
) (
   input  logic                               clk_25mHz,
   input  logic                               reset,
   input  logic [X_WIDTH-1:0]                 x,
   input  logic [Y_WIDTH-1:0]                 y,
   input  logic                               active,
   input  logic                               screenEnd,
   input  logic [COLOR_BITS-1:0]              bg_color,
   input  logic [NUM_BOXES*X_WIDTH-1:0]       box_cx,
   input  logic [NUM_BOXES*Y_WIDTH-1:0]       box_cy,
   input  logic [NUM_BOXES*HALF_WIDTH-1:0]    box_half,
   input  logic [NUM_BOXES*COLOR_BITS-1:0]    box_color,
   input  logic [NUM_BOXES-1:0]               box_en,
   output logic [COLOR_BITS-1:0]              color_out,
   output logic                               hit_valid,
   output logic [$clog2(NUM_BOXES)-1:0]       hit_index,
   output logic [NUM_BOXES-1:0]               collision_flags,
   output logic                               collision_strobe
);
   localparam int IW = $clog2(NUM_BOXES);
   logic                            se_d, frame_edge;
   logic [NUM_BOXES*X_WIDTH-1:0]    sh_cx;
   logic [NUM_BOXES*Y_WIDTH-1:0]    sh_cy;
   logic [NUM_BOXES*HALF_WIDTH-1:0] sh_half;
   logic [NUM_BOXES*COLOR_BITS-1:0] sh_color;
   logic [NUM_BOXES-1:0]            sh_en, bnd_en, hit, hit_s1;
   logic [X_WIDTH-1:0]              bl [NUM_BOXES];
   logic [X_WIDTH-1:0]              br [NUM_BOXES];
   logic [Y_WIDTH-1:0]              bt [NUM_BOXES];
   logic [Y_WIDTH-1:0]              bb [NUM_BOXES];
   logic                            active_s1;
   logic [COLOR_BITS-1:0]           bg_s1;
   logic [IW-1:0]                   win;

   function automatic logic [X_WIDTH-1:0] x_lo(input logic [X_WIDTH-1:0] c, input logic [HALF_WIDTH-1:0] h);
      return c < X_WIDTH'(h) ? '0 : c - X_WIDTH'(h);
   endfunction

   function automatic logic [X_WIDTH-1:0] x_hi(input logic [X_WIDTH-1:0] c, input logic [HALF_WIDTH-1:0] h);
      logic [X_WIDTH:0] s;
      s = {1'b0, c} + (X_WIDTH+1)'(h);
      return s[X_WIDTH] ? '1 : s[X_WIDTH-1:0];
   endfunction

   function automatic logic [Y_WIDTH-1:0] y_lo(input logic [Y_WIDTH-1:0] c, input logic [HALF_WIDTH-1:0] h);
      return c < Y_WIDTH'(h) ? '0 : c - Y_WIDTH'(h);
   endfunction

   function automatic logic [Y_WIDTH-1:0] y_hi(input logic [Y_WIDTH-1:0] c, input logic [HALF_WIDTH-1:0] h);
      logic [Y_WIDTH:0] s;
      s = {1'b0, c} + (Y_WIDTH+1)'(h);
      return s[Y_WIDTH] ? '1 : s[Y_WIDTH-1:0];
   endfunction

   assign frame_edge = screenEnd & ~se_d;

   // se_d follows screenEnd even in reset, so a pulse held across reset release yields no edge
   always_ff @(posedge clk_25mHz) begin
      se_d <= screenEnd;
      if (!reset) begin
         sh_cx    <= '0;
         sh_cy    <= '0;
         sh_half  <= '0;
         sh_color <= '0;
         sh_en    <= '0;
      end else if (frame_edge) begin
         sh_cx    <= box_cx;
         sh_cy    <= box_cy;
         sh_half  <= box_half;
         sh_color <= box_color;
         sh_en    <= box_en;
      end
   end

   always_ff @(posedge clk_25mHz) begin
      bnd_en <= reset ? sh_en : '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
         bl[i] <= reset ? x_lo(sh_cx[i*X_WIDTH +: X_WIDTH], sh_half[i*HALF_WIDTH +: HALF_WIDTH]) : '0;
         br[i] <= reset ? x_hi(sh_cx[i*X_WIDTH +: X_WIDTH], sh_half[i*HALF_WIDTH +: HALF_WIDTH]) : '0;
         bt[i] <= reset ? y_lo(sh_cy[i*Y_WIDTH +: Y_WIDTH], sh_half[i*HALF_WIDTH +: HALF_WIDTH]) : '0;
         bb[i] <= reset ? y_hi(sh_cy[i*Y_WIDTH +: Y_WIDTH], sh_half[i*HALF_WIDTH +: HALF_WIDTH]) : '0;
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_BOXES; i++)
         hit[i] = bnd_en[i] && x >= bl[i] && x <= br[i] && y >= bt[i] && y <= bb[i];
   end

   always_comb begin
      win = '0;
      for (int i = NUM_BOXES-1; i >= 0; i--)
         if (hit_s1[i]) win = IW'(i);
   end

   always_ff @(posedge clk_25mHz) begin
      if (!reset) begin
         hit_s1    <= '0;
         active_s1 <= 1'b0;
         bg_s1     <= '0;
         color_out <= '0;
         hit_valid <= 1'b0;
         hit_index <= '0;
      end else begin
         hit_s1    <= hit;
         active_s1 <= active;
         bg_s1     <= bg_color;
         color_out <= active_s1 ? (|hit_s1 ? sh_color[win*COLOR_BITS +: COLOR_BITS] : bg_s1) : '0;
         hit_valid <= |hit_s1;
         hit_index <= win;
      end
   end

`ifdef BOX_COLLISION_EN
   logic [NUM_BOXES-1:0] acc;

   always_ff @(posedge clk_25mHz) begin
      if (!reset) begin
         acc              <= '0;
         collision_flags  <= '0;
         collision_strobe <= 1'b0;
      end else begin
         collision_strobe <= frame_edge;
         if (frame_edge) begin
            collision_flags <= acc;
            acc             <= '0;
         end else begin
            acc <= acc | ({NUM_BOXES{active_s1 & hit_s1[0]}} & hit_s1 & ~NUM_BOXES'(1));
         end
      end
   end
`else
   assign collision_flags  = '0;
   assign collision_strobe = 1'b0;
`endif
endmodule
